fpu_result_sequencer: RTL
=========================

FPU_RESULT_SEQUENCER -- requirements
Module: fpu_result_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, result/operand datapath width.
REQ-002 SHALL have parameter RD_W, default 5, destination register tag width.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port clear  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  pipeline presents an FPU operation.
REQ-006 SHALL have port req_ready  output  1  sequencer accepts the operation this cycle.
REQ-007 SHALL have port req_op  input  4  FPU opcode (same fpuOp encoding as the pipeline stall logic).
REQ-008 SHALL have port req_rd  input  RD_W  destination tag carried to the response.
REQ-009 SHALL have port fpu_start  output  1  one-cycle start pulse to the FPU datapath.
REQ-010 SHALL have port fpu_result  input  DATA_W  FPU datapath result.
REQ-011 SHALL have port fpu_flags  input  5  FPU exception flags (NV,DZ,OF,UF,NX).
REQ-012 SHALL have port rsp_valid  output  1  captured result available to writeback.
REQ-013 SHALL have port rsp_ready  input  1  writeback consumes the response.
REQ-014 SHALL have port rsp_data  output  DATA_W  captured result.
REQ-015 SHALL have port rsp_rd  output  RD_W  tag of the captured result.
REQ-016 SHALL have port rsp_flags  output  5  captured flags.
REQ-017 SHALL have port rsp_illegal  output  1  response belongs to opcode 14 or 15.
REQ-018 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-019 SHALL implement states IDLE, EXEC, HOLD.
REQ-020 Latency N per opcode SHALL be: 0,1->7; 2->5; 3->6; 4->0; 5->1; 6->16; 7->1; 8,9->6; 10-13->12; 14,15->0.
REQ-021 Accept SHALL occur in cycle T when req_valid && req_ready; fpu_start = req_valid && req_ready (combinational, exactly one cycle).
REQ-022 At accept edge: latch req_op, req_rd; load 5-bit counter with N; go EXEC if N>0, else capture result and go HOLD.
REQ-023 In EXEC: if counter==1, capture fpu_result/fpu_flags and go HOLD; else decrement counter; result captured is the one present in cycle T+N.
REQ-024 rsp_valid SHALL be 1 exactly in HOLD; first rsp_valid cycle is T+N+1.
REQ-025 rsp_data/rsp_rd/rsp_flags/rsp_illegal SHALL stay stable while rsp_valid && !rsp_ready.
REQ-026 In HOLD with rsp_ready=1: go IDLE (or directly re-accept, see REQ-032).
REQ-027 Opcodes 14/15: rsp_data=0, rsp_flags=5'b10000, rsp_illegal=1; fpu_start still pulses.
REQ-028 req_ready SHALL be 0 in EXEC; req_valid in EXEC/HOLD without acceptance SHALL be ignored.
REQ-029 Counter arithmetic SHALL be 5-bit unsigned, never wraps (max load 16).

Reset
REQ-030 clear=1 at a rising edge SHALL force IDLE, counter=0, rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_flags=0, rsp_illegal=0, busy=0; fpu_start=0 while clear=1.
REQ-031 clear during EXEC or HOLD SHALL discard the in-flight operation with no response produced.

Configuration
REQ-032 Macro FPU_RSP_BYPASS_EN defined: req_ready = IDLE || (HOLD && rsp_ready), allowing back-to-back accept in the response-consume cycle; undefined: req_ready = IDLE only (one idle cycle between operations).

Structure
REQ-033 Package fpu_pkg SHALL hold opcode localparams, the state enum typedef and the latency constants.
REQ-034 Sub-module fpu_latency_lut SHALL map req_op to N combinationally; all else in fpu_result_sequencer.

Verification
REQ-035 op=2, rd=7, rsp_ready=1: fpu_start at T, fpu_result=0x3F800000 at T+5 -> rsp_valid at T+6, rsp_data=0x3F800000, rsp_rd=7.
REQ-036 op=4 (N=0), fpu_result=0x40000000 at T -> rsp_valid at T+1 with that value; busy high only during HOLD.
REQ-037 op=6, rsp_ready=0 for 5 cycles after rsp_valid -> outputs held stable, req_ready=0 throughout, response consumed on 6th cycle.
REQ-038 op=15 -> rsp_valid at T+1, rsp_data=0, rsp_flags=5'b10000, rsp_illegal=1.
REQ-039 op=10 accepted, clear asserted at T+4 -> next cycle IDLE, rsp_valid never asserts, req_ready=1.
REQ-040 Two queued op=5 with rsp_ready=1: with FPU_RSP_BYPASS_EN second start at T+2; without it at T+3.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared opcode, latency and state definitions for the FPU result sequencer.
package fpu_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 5;
  localparam int unsigned CNT_W  = 5;

  localparam logic [OP_W-1:0] OP_FADD    = 4'd0;
  localparam logic [OP_W-1:0] OP_FSUB    = 4'd1;
  localparam logic [OP_W-1:0] OP_FMUL    = 4'd2;
  localparam logic [OP_W-1:0] OP_FMADD   = 4'd3;
  localparam logic [OP_W-1:0] OP_FSGNJ   = 4'd4;
  localparam logic [OP_W-1:0] OP_FMV     = 4'd5;
  localparam logic [OP_W-1:0] OP_FDIV    = 4'd6;
  localparam logic [OP_W-1:0] OP_FCMP    = 4'd7;
  localparam logic [OP_W-1:0] OP_FCVT_IF = 4'd8;
  localparam logic [OP_W-1:0] OP_FCVT_FI = 4'd9;
  localparam logic [OP_W-1:0] OP_FSQRT   = 4'd10;
  localparam logic [OP_W-1:0] OP_FDIV_D  = 4'd11;
  localparam logic [OP_W-1:0] OP_FSQRT_D = 4'd12;
  localparam logic [OP_W-1:0] OP_FREM    = 4'd13;
  localparam logic [OP_W-1:0] OP_ILL0    = 4'd14;
  localparam logic [OP_W-1:0] OP_ILL1    = 4'd15;

  localparam logic [CNT_W-1:0] LAT_ADD  = 5'd7;
  localparam logic [CNT_W-1:0] LAT_MUL  = 5'd5;
  localparam logic [CNT_W-1:0] LAT_FMA  = 5'd6;
  localparam logic [CNT_W-1:0] LAT_SGNJ = 5'd0;
  localparam logic [CNT_W-1:0] LAT_MV   = 5'd1;
  localparam logic [CNT_W-1:0] LAT_DIV  = 5'd16;
  localparam logic [CNT_W-1:0] LAT_CMP  = 5'd1;
  localparam logic [CNT_W-1:0] LAT_CVT  = 5'd6;
  localparam logic [CNT_W-1:0] LAT_ITER = 5'd12;
  localparam logic [CNT_W-1:0] LAT_ILL  = 5'd0;

  localparam logic [FLAG_W-1:0] ILLEGAL_FLAGS = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_HOLD
  } state_e;

  function automatic logic is_illegal(input logic [OP_W-1:0] op);
    return (op == OP_ILL0) || (op == OP_ILL1);
  endfunction

endpackage

// File: rtl/fpu_latency_lut.sv
// Combinational map from FPU opcode to result latency in cycles.
module fpu_latency_lut
  import fpu_pkg::*;
(
  input  logic [3:0] op,
  output logic [4:0] lat
);

  always_comb begin
    lat = LAT_ILL;
    case (op)
      OP_FADD, OP_FSUB:                         lat = LAT_ADD;
      OP_FMUL:                                  lat = LAT_MUL;
      OP_FMADD:                                 lat = LAT_FMA;
      OP_FSGNJ:                                 lat = LAT_SGNJ;
      OP_FMV:                                   lat = LAT_MV;
      OP_FDIV:                                  lat = LAT_DIV;
      OP_FCMP:                                  lat = LAT_CMP;
      OP_FCVT_IF, OP_FCVT_FI:                   lat = LAT_CVT;
      OP_FSQRT, OP_FDIV_D, OP_FSQRT_D, OP_FREM: lat = LAT_ITER;
      default:                                  lat = LAT_ILL;
    endcase
  end

endmodule

// File: rtl/fpu_result_sequencer.sv
// Issues FPU operations, waits the opcode latency and holds the result for writeback.
// Define FPU_RSP_BYPASS_EN to allow re-accept in the response-consume cycle.
module fpu_result_sequencer
  import fpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [RD_W-1:0]   req_rd,
  output logic              fpu_start,
  input  logic [DATA_W-1:0] fpu_result,
  input  logic [4:0]        fpu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [RD_W-1:0]   rsp_rd,
  output logic [4:0]        rsp_flags,
  output logic              rsp_illegal,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [RD_W-1:0]   rsp_rd_q, rsp_rd_d;
  logic [4:0]        rsp_flags_q, rsp_flags_d;
  logic              rsp_illegal_q, rsp_illegal_d;
  logic [4:0]        lat;
  logic              accept;

  fpu_latency_lut u_lut (
    .op  (req_op),
    .lat (lat)
  );

`ifdef FPU_RSP_BYPASS_EN
  assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && rsp_ready);
`else
  assign req_ready = (state_q == ST_IDLE);
`endif

  assign accept      = req_valid && req_ready && !clear;
  assign fpu_start   = accept;
  assign rsp_valid   = (state_q == ST_HOLD);
  assign busy        = (state_q != ST_IDLE);
  assign rsp_data    = rsp_data_q;
  assign rsp_rd      = rsp_rd_q;
  assign rsp_flags   = rsp_flags_q;
  assign rsp_illegal = rsp_illegal_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    rd_d          = rd_q;
    rsp_data_d    = rsp_data_q;
    rsp_rd_d      = rsp_rd_q;
    rsp_flags_d   = rsp_flags_q;
    rsp_illegal_d = rsp_illegal_q;

    case (state_q)
      ST_EXEC: begin
        if (cnt_q == 5'd1) begin
          state_d       = ST_HOLD;
          cnt_d         = '0;
          rsp_data_d    = is_illegal(op_q) ? '0 : fpu_result;
          rsp_flags_d   = is_illegal(op_q) ? ILLEGAL_FLAGS : fpu_flags;
          rsp_illegal_d = is_illegal(op_q);
          rsp_rd_d      = rd_q;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_HOLD: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: ;
    endcase

    // Accept overrides the HOLD->IDLE step so a bypassed re-accept starts cleanly.
    if (accept) begin
      op_d  = req_op;
      rd_d  = req_rd;
      cnt_d = lat;
      if (lat != 5'd0) begin
        state_d = ST_EXEC;
      end else begin
        state_d       = ST_HOLD;
        rsp_data_d    = is_illegal(req_op) ? '0 : fpu_result;
        rsp_flags_d   = is_illegal(req_op) ? ILLEGAL_FLAGS : fpu_flags;
        rsp_illegal_d = is_illegal(req_op);
        rsp_rd_d      = req_rd;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      rd_q          <= '0;
      rsp_data_q    <= '0;
      rsp_rd_q      <= '0;
      rsp_flags_q   <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      rd_q          <= rd_d;
      rsp_data_q    <= rsp_data_d;
      rsp_rd_q      <= rsp_rd_d;
      rsp_flags_q   <= rsp_flags_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

endmodule
